// File: rtl/speed_tick_receiver.sv
// ---------------------------------------------------------------------------
// speed_tick_receiver
//   Brings a slow, asynchronous "speed" toggle into the clk domain. Each
//   counted edge becomes a one-cycle tick enable. The block also measures the
//   edge-to-edge period and flags a source that has stopped toggling.
//
// Parameters
//   SYNC_STAGES : synchronizer depth on speed_in (2..4)
//   CNT_W       : width of the gap counter and of period
//   TIMEOUT     : cycles without a counted edge before stalled asserts
//   RISING_ONLY : 0 = count both edges, 1 = count rising edges only
//
// Ports
//   clk, rst_n   : system clock, async active-low reset
//   speed_in     : slow toggle, asynchronous to clk
//   enable       : 1 = measure and emit ticks, 0 = hold idle
//   tick         : one-cycle pulse per counted edge
//   rise / fall  : one-cycle pulses on synchronized edges (gated by enable)
//   period       : clk cycles between the last two counted edges
//   period_valid : period holds a genuine measurement
//   stalled      : no counted edge for TIMEOUT cycles
//   edge_count   : running tick count, wraps at 16 bits
// ---------------------------------------------------------------------------
module speed_tick_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 50000000,
  parameter bit          RISING_ONLY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             speed_in,
  input  logic             enable,
  output logic             tick,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // no reference edge yet
    S_ARMED  = 2'd1,  // one edge seen, measuring
    S_LOCKED = 2'd2,  // period valid
    S_STALL  = 2'd3   // source has stopped
  } state_t;

  localparam logic [CNT_W-1:0] GCNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_tick;
  logic                   r_rise;
  logic                   r_fall;
  logic [CNT_W-1:0]       r_gcnt;
  logic [CNT_W-1:0]       r_period;
  logic                   r_period_valid;
  logic                   r_stalled;
  logic [15:0]            r_edge_count;
  state_t                 r_state;

  logic                   w_rise;
  logic                   w_fall;
  logic                   w_counted;
  logic                   w_tick;
  logic [CNT_W-1:0]       w_gcnt_inc;
  logic                   w_timeout;

  // Synchronizer plus history flop. It ignores enable so that re-enabling
  // compares against an up-to-date history and cannot see a stale edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], speed_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise     =  r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_fall     = ~r_sync[SYNC_STAGES-1] &  r_hist;
  assign w_counted  = RISING_ONLY ? w_rise : (w_rise | w_fall);
  assign w_tick     = w_counted & enable;
  // Saturating increment, shared by the gap counter and the period capture.
  assign w_gcnt_inc = (r_gcnt == GCNT_MAX) ? GCNT_MAX : r_gcnt + CNT_W'(1);
  assign w_timeout  = (r_gcnt >= TIMEOUT_M1);

  // Registered one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_tick <= w_tick;
      r_rise <= w_rise & enable;
      r_fall <= w_fall & enable;
    end
  end

  // Gap counter: cycles since the last tick, parked at 0 while idle/disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gcnt <= '0;
    end else if (!enable || r_state == S_IDLE || w_tick) begin
      r_gcnt <= '0;
    end else begin
      r_gcnt <= w_gcnt_inc;
    end
  end

  // Measurement FSM with registered status outputs. A tick is tested before
  // the timeout, so a tick on the TIMEOUT-1 cycle wins over the stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_stalled      <= 1'b0;
      r_edge_count   <= '0;
    end else begin
      if (!enable) begin
        r_state        <= S_IDLE;
        r_period_valid <= 1'b0;
        r_stalled      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_tick) r_state <= S_ARMED;
          end
          S_ARMED: begin
            if (w_tick) begin
              r_state        <= S_LOCKED;
              r_period       <= w_gcnt_inc;
              r_period_valid <= 1'b1;
            end else if (w_timeout) begin
              r_state   <= S_STALL;
              r_stalled <= 1'b1;
            end
          end
          S_LOCKED: begin
            if (w_tick) begin
              r_period <= w_gcnt_inc;
            end else if (w_timeout) begin
              r_state        <= S_STALL;
              r_stalled      <= 1'b1;
              r_period_valid <= 1'b0;
            end
          end
          S_STALL: begin
            // Restart: the stalled gap is reported but not trusted yet.
            if (w_tick) begin
              r_state   <= S_ARMED;
              r_period  <= w_gcnt_inc;
              r_stalled <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
      if (w_tick) r_edge_count <= r_edge_count + 16'd1;
    end
  end

  assign tick         = r_tick;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign stalled      = r_stalled;
  assign edge_count   = r_edge_count;

endmodule
